glitch_sweep_sequencer: RTL and testbench

//  Automates glitch parameter sweeps. Sits between command_processor and the resetter/offset/duration chain on sys_clk.

---
 rtl/glitch_sweep_sequencer_if.sv | 27 ++
 rtl/glitch_sweep_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_glitch_sweep_sequencer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glitch_sweep_sequencer_if.sv
// Result record stream from the sweep sequencer: one record per glitch attempt,
// transferred on res_valid & res_ready.
interface glitch_sweep_sequencer_if #(
    parameter int unsigned W = 32
) ();
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_offset;
    logic [W-1:0] res_duration;
    logic [1:0]   res_status;

    modport master (
        output res_valid,
        output res_offset,
        output res_duration,
        output res_status,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_offset,
        input  res_duration,
        input  res_status,
        output res_ready
    );
endinterface

// File: rtl/glitch_sweep_sequencer.sv
// Glitch parameter sweep sequencer: walks offset x duration x repeats, runs one
// reset/arm/glitch/response attempt per step and streams one result record per attempt.
module glitch_sweep_sequencer #(
    parameter int unsigned W          = 32,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [W-1:0]             i_cfg_ofs_start,
    input  logic [W-1:0]             i_cfg_ofs_end,
    input  logic [W-1:0]             i_cfg_ofs_step,
    input  logic [W-1:0]             i_cfg_dur_start,
    input  logic [W-1:0]             i_cfg_dur_end,
    input  logic [W-1:0]             i_cfg_dur_step,
    input  logic [7:0]               i_cfg_repeats,
    output logic                     o_tgt_reset,
    output logic                     o_arm,
    output logic [W-1:0]             o_offset,
    output logic [W-1:0]             o_duration,
    input  logic                     i_glitch_done,
    input  logic                     i_resp_valid,
    input  logic                     i_resp_ok,
    glitch_sweep_sequencer_if.master res_if,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_cfg_err
);

    localparam int unsigned CMax    = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int unsigned CW      = $clog2(CMax + 1);
    localparam logic [CW-1:0] RstLast = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TmoLast = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle, StLoad, StReset, StArm, StWaitGlitch, StWaitResp, StReport, StNext, StDone
    } state_e;

    state_e       r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [W-1:0] r_offset, w_offset_nxt;
    logic [W-1:0] r_duration, w_duration_nxt;
    logic [7:0]   r_rep, w_rep_nxt;
    logic [1:0]   r_status, w_status_nxt;
    logic         r_cfg_err, w_cfg_err_nxt;
    logic         w_latch;

    logic [W-1:0] r_ofs_start, r_ofs_end, r_ofs_step;
    logic [W-1:0] r_dur_start, r_dur_end, r_dur_step;
    logic [7:0]   r_repeats;

    // Sums carry one extra bit so an overflow reads as "past the end", never a wrap.
    logic [W:0]   w_dur_sum, w_ofs_sum;
    logic [8:0]   w_rep_inc;

    assign w_dur_sum = {1'b0, r_duration} + {1'b0, r_dur_step};
    assign w_ofs_sum = {1'b0, r_offset} + {1'b0, r_ofs_step};
    assign w_rep_inc = {1'b0, r_rep} + 9'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_offset_nxt   = r_offset;
        w_duration_nxt = r_duration;
        w_rep_nxt      = r_rep;
        w_status_nxt   = r_status;
        w_cfg_err_nxt  = r_cfg_err;
        w_latch        = 1'b0;

        if (i_abort && (r_state != StIdle)) begin
            w_state_nxt = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        w_latch       = 1'b1;
                        w_cfg_err_nxt = 1'b0;
                        w_state_nxt   = StLoad;
                    end
                end
                StLoad: begin
                    if ((r_ofs_end < r_ofs_start) || (r_dur_end < r_dur_start)) begin
                        w_cfg_err_nxt = 1'b1;
                        w_state_nxt   = StDone;
                    end else begin
                        w_offset_nxt   = r_ofs_start;
                        w_duration_nxt = r_dur_start;
                        w_rep_nxt      = '0;
                        w_state_nxt    = StReset;
                    end
                end
                StReset: begin
                    if (r_cnt == RstLast) w_state_nxt = StArm;
                end
                StArm: w_state_nxt = StWaitGlitch;
                StWaitGlitch: begin
                    if (i_glitch_done) begin
                        w_state_nxt = StWaitResp;
                    end else if (r_cnt == TmoLast) begin
                        w_status_nxt = 2'b11;
                        w_state_nxt  = StReport;
                    end
                end
                StWaitResp: begin
                    if (i_resp_valid) begin
                        w_status_nxt = {i_resp_ok, ~i_resp_ok};
                        w_state_nxt  = StReport;
                    end else if (r_cnt == TmoLast) begin
                        w_status_nxt = 2'b00;
                        w_state_nxt  = StReport;
                    end
                end
                StReport: begin
                    if (res_if.res_ready) w_state_nxt = StNext;
                end
                StNext: begin
                    w_state_nxt = StReset;
                    if (w_rep_inc < {1'b0, r_repeats}) begin
                        w_rep_nxt = w_rep_inc[7:0];
                    end else begin
                        w_rep_nxt = '0;
                        if (w_dur_sum <= {1'b0, r_dur_end}) begin
                            w_duration_nxt = w_dur_sum[W-1:0];
                        end else begin
                            w_duration_nxt = r_dur_start;
                            if (w_ofs_sum <= {1'b0, r_ofs_end}) begin
                                w_offset_nxt = w_ofs_sum[W-1:0];
                            end else begin
                                w_state_nxt = StDone;
                            end
                        end
                    end
                end
                StDone:  w_state_nxt = StIdle;
                default: w_state_nxt = StIdle;
            endcase
        end

        // One counter serves RESET and both waits; it restarts on every state change.
        w_cnt_nxt = (w_state_nxt != r_state) ? '0 : r_cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_offset    <= '0;
            r_duration  <= '0;
            r_rep       <= '0;
            r_status    <= '0;
            r_cfg_err   <= 1'b0;
            r_ofs_start <= '0;
            r_ofs_end   <= '0;
            r_ofs_step  <= '0;
            r_dur_start <= '0;
            r_dur_end   <= '0;
            r_dur_step  <= '0;
            r_repeats   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_offset   <= w_offset_nxt;
            r_duration <= w_duration_nxt;
            r_rep      <= w_rep_nxt;
            r_status   <= w_status_nxt;
            r_cfg_err  <= w_cfg_err_nxt;
            if (w_latch) begin
                r_ofs_start <= i_cfg_ofs_start;
                r_ofs_end   <= i_cfg_ofs_end;
                r_ofs_step  <= (i_cfg_ofs_step == '0) ? W'(1) : i_cfg_ofs_step;
                r_dur_start <= i_cfg_dur_start;
                r_dur_end   <= i_cfg_dur_end;
                r_dur_step  <= (i_cfg_dur_step == '0) ? W'(1) : i_cfg_dur_step;
                r_repeats   <= (i_cfg_repeats == '0) ? 8'd1 : i_cfg_repeats;
            end
        end
    end

    assign o_tgt_reset         = (r_state == StReset);
    assign o_arm               = (r_state == StArm);
    assign o_offset            = r_offset;
    assign o_duration          = r_duration;
    assign o_busy              = (r_state != StIdle) && (r_state != StDone);
    assign o_done              = (r_state == StDone);
    assign o_cfg_err           = r_cfg_err;
    assign res_if.res_valid    = (r_state == StReport);
    assign res_if.res_offset   = r_offset;
    assign res_if.res_duration = r_duration;
    assign res_if.res_status   = r_status;

endmodule

// File: tb/tb_glitch_sweep_sequencer.sv
// Directed bench for glitch_sweep_sequencer: scripted target responder, stalling
// result consumer and hand-computed record lists per sweep.
module tb_glitch_sweep_sequencer;
    localparam int unsigned W         = 32;
    localparam int unsigned RstCycles = 16;
    localparam int unsigned Timeout   = 40;

    typedef struct {
        logic [31:0] ofs;
        logic [31:0] dur;
        logic [1:0]  st;
        int          t;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_abort;
    logic [31:0] i_cfg_ofs_start, i_cfg_ofs_end, i_cfg_ofs_step;
    logic [31:0] i_cfg_dur_start, i_cfg_dur_end, i_cfg_dur_step;
    logic [7:0]  i_cfg_repeats;
    logic        o_tgt_reset, o_arm, o_busy, o_done, o_cfg_err;
    logic [31:0] o_offset, o_duration;
    logic        i_glitch_done, i_resp_valid, i_resp_ok;

    glitch_sweep_sequencer_if #(.W(W)) res_if ();

    glitch_sweep_sequencer #(.W(W), .RST_CYCLES(RstCycles), .TIMEOUT(Timeout)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_cfg_ofs_start (i_cfg_ofs_start),
        .i_cfg_ofs_end   (i_cfg_ofs_end),
        .i_cfg_ofs_step  (i_cfg_ofs_step),
        .i_cfg_dur_start (i_cfg_dur_start),
        .i_cfg_dur_end   (i_cfg_dur_end),
        .i_cfg_dur_step  (i_cfg_dur_step),
        .i_cfg_repeats   (i_cfg_repeats),
        .o_tgt_reset     (o_tgt_reset),
        .o_arm           (o_arm),
        .o_offset        (o_offset),
        .o_duration      (o_duration),
        .i_glitch_done   (i_glitch_done),
        .i_resp_valid    (i_resp_valid),
        .i_resp_ok       (i_resp_ok),
        .res_if          (res_if),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_cfg_err       (o_cfg_err)
    );

    initial forever #5 clk = ~clk;

    int   n_total = 0, n_bad = 0, cyc = 0;
    int   glitch_dly = 0, resp_dly = 0, t_gd = 0, t_arm = 0;
    logic resp_ok_cfg = 1'b0;
    bit   banner = 1'b0;
    int   stall_len = 0, stall_peak = 0;
    bit   unstable = 1'b0, stall_bad = 1'b0;
    int   done_cnt = 0;
    logic done_err = 1'b0, done_busy = 1'b0;
    bit   done_wide = 1'b0;
    int   rst_runs[$], arm_runs[$];
    rec_t recs[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Target model: glitch_done glitch_dly cycles into WAIT_GLITCH, then the
    // response resp_dly cycles into WAIT_RESP (-1 = never).
    initial begin
        int g_cnt, rs_cnt;
        g_cnt = -1;
        rs_cnt = -1;
        i_glitch_done = 1'b0;
        i_resp_valid = 1'b0;
        i_resp_ok = 1'b0;
        forever begin
            @(posedge clk); #1;
            i_glitch_done = 1'b0;
            i_resp_valid = 1'b0;
            i_resp_ok = 1'b0;
            if (banner && o_tgt_reset) begin
                i_resp_valid = 1'b1;
                i_resp_ok = 1'b1;
            end
            if (g_cnt == 0) begin
                i_glitch_done = 1'b1;
                g_cnt = -1;
                t_gd = cyc + 1;
                rs_cnt = resp_dly;
            end else if (g_cnt > 0) begin
                g_cnt--;
            end else if (rs_cnt == 0) begin
                i_resp_valid = 1'b1;
                i_resp_ok = resp_ok_cfg;
                rs_cnt = -1;
            end else if (rs_cnt > 0) begin
                rs_cnt--;
            end
            if (o_arm) begin
                t_arm = cyc;
                g_cnt = glitch_dly;
            end
        end
    end

    // Consumer: holds ready low for stall_len cycles of each record, then takes it.
    initial begin
        bit          prev_v;
        int          stall_cnt;
        logic [65:0] snap;
        int          t_first;
        prev_v = 1'b0;
        stall_cnt = 0;
        snap = '0;
        t_first = 0;
        res_if.res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (res_if.res_valid) begin
                if (!prev_v) begin
                    t_first = cyc;
                    snap = {res_if.res_offset, res_if.res_duration, res_if.res_status};
                end else if (snap != {res_if.res_offset, res_if.res_duration,
                                      res_if.res_status}) begin
                    unstable = 1'b1;
                end
                if (stall_cnt < stall_len) begin
                    if (o_tgt_reset || o_arm || !o_busy) stall_bad = 1'b1;
                    res_if.res_ready = 1'b0;
                    stall_cnt++;
                    if (stall_cnt > stall_peak) stall_peak = stall_cnt;
                end else begin
                    res_if.res_ready = 1'b1;
                    recs.push_back('{res_if.res_offset, res_if.res_duration,
                                     res_if.res_status, t_first});
                    stall_cnt = 0;
                end
                prev_v = 1'b1;
            end else begin
                res_if.res_ready = 1'b0;
                prev_v = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    initial begin
        int  rl, al;
        bit  prev_done;
        rl = 0;
        al = 0;
        prev_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (o_tgt_reset) rl++;
            else if (rl > 0) begin
                rst_runs.push_back(rl);
                rl = 0;
            end
            if (o_arm) al++;
            else if (al > 0) begin
                arm_runs.push_back(al);
                al = 0;
            end
            if (o_done) begin
                done_cnt++;
                done_err = o_cfg_err;
                done_busy = o_busy;
                if (prev_done) done_wide = 1'b1;
            end
            prev_done = o_done;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_sweep(input logic [31:0] os, input logic [31:0] oe,
                               input logic [31:0] ostep, input logic [31:0] ds,
                               input logic [31:0] de, input logic [31:0] dstep,
                               input logic [7:0] rep);
        recs.delete();
        rst_runs.delete();
        arm_runs.delete();
        i_cfg_ofs_start = os;
        i_cfg_ofs_end   = oe;
        i_cfg_ofs_step  = ostep;
        i_cfg_dur_start = ds;
        i_cfg_dur_end   = de;
        i_cfg_dur_step  = dstep;
        i_cfg_repeats   = rep;
        i_start = 1'b1;
        @(posedge clk); #2;
        i_start = 1'b0;
        check_eq("busy_after_start", o_busy, 1);
        check_eq("cfg_err_cleared", o_cfg_err, 0);
    endtask

    // poke: fire a start with altered cfg mid-sweep, which must be ignored
    task automatic wait_done(input string tag, input int budget, input bit poke);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #2;
            if (poke && i == 30) begin
                i_start = 1'b1;
                i_cfg_ofs_end = 32'd1000;
                i_cfg_repeats = 8'd5;
            end else begin
                i_start = 1'b0;
            end
            if (done_cnt != d0) seen = 1'b1;
        end
        i_start = 1'b0;
        check_eq({tag, "_done_seen"}, 32'(seen), 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic check_common(input string tag, input int nrec);
        bit r_ok, a_ok;
        r_ok = 1'b1;
        a_ok = 1'b1;
        foreach (rst_runs[i]) if (rst_runs[i] != RstCycles) r_ok = 1'b0;
        foreach (arm_runs[i]) if (arm_runs[i] != 1) a_ok = 1'b0;
        check_eq({tag, "_nrec"}, recs.size(), nrec);
        check_eq({tag, "_nrst"}, rst_runs.size(), nrec);
        check_eq({tag, "_narm"}, arm_runs.size(), nrec);
        check_eq({tag, "_rst_len"}, 32'(r_ok), 1);
        check_eq({tag, "_arm_len"}, 32'(a_ok), 1);
        check_eq({tag, "_cfg_err"}, done_err, 0);
        check_eq({tag, "_busy_at_done"}, done_busy, 0);
        check_eq({tag, "_done_width"}, 32'(done_wide), 0);
    endtask

    task automatic check_rec(input int i, input logic [31:0] ofs, input logic [31:0] dur,
                             input logic [1:0] st);
        check_eq($sformatf("rec%0d_present", i), 32'(recs.size() > i), 1);
        if (recs.size() > i) begin
            check_eq($sformatf("rec%0d_ofs", i), recs[i].ofs, ofs);
            check_eq($sformatf("rec%0d_dur", i), recs[i].dur, dur);
            check_eq($sformatf("rec%0d_status", i), recs[i].st, st);
        end
    endtask

    initial begin
        int d0;
        bit seen;
        rst = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_cfg_ofs_start = '0;
        i_cfg_ofs_end = '0;
        i_cfg_ofs_step = '0;
        i_cfg_dur_start = '0;
        i_cfg_dur_end = '0;
        i_cfg_dur_step = '0;
        i_cfg_repeats = '0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_tgt_reset", o_tgt_reset, 0);
        check_eq("rst_arm", o_arm, 0);
        check_eq("rst_offset", o_offset, 0);
        check_eq("rst_duration", o_duration, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_cfg_err", o_cfg_err, 0);
        check_eq("rst_res_valid", res_if.res_valid, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Offset sweep, duration step 0 behaves as 1
        start_sweep(32'd100, 32'd102, 32'd1, 32'd5, 32'd5, 32'd0, 8'd1);
        wait_done("ofs3", 2000, 1'b0);
        check_common("ofs3", 3);
        for (int i = 0; i < 3; i++) check_rec(i, 32'd100 + 32'(i), 32'd5, 2'b01);

        // Duration sweep with repeats; a mid-sweep start must not disturb it
        start_sweep(32'd0, 32'd0, 32'd1, 32'd10, 32'd30, 32'd10, 8'd2);
        wait_done("dur3x2", 3000, 1'b1);
        check_common("dur3x2", 6);
        for (int i = 0; i < 6; i++) check_rec(i, 32'd0, 32'd10 * 32'(i / 2 + 1), 2'b01);

        // repeats 0 runs once, offset step 0 behaves as 1
        start_sweep(32'd3, 32'd4, 32'd0, 32'd1, 32'd1, 32'd1, 8'd0);
        wait_done("rep0", 2000, 1'b0);
        check_common("rep0", 2);
        check_rec(0, 32'd3, 32'd1, 2'b01);
        check_rec(1, 32'd4, 32'd1, 2'b01);

        // Response timeout
        resp_dly = -1;
        start_sweep(32'd7, 32'd7, 32'd1, 32'd3, 32'd3, 32'd1, 8'd1);
        wait_done("resp_tmo", 2000, 1'b0);
        check_common("resp_tmo", 1);
        check_rec(0, 32'd7, 32'd3, 2'b00);
        if (recs.size() > 0) check_eq("resp_tmo_latency", recs[0].t - t_gd, Timeout);

        // No glitch_done at all
        glitch_dly = -1;
        start_sweep(32'd8, 32'd8, 32'd1, 32'd4, 32'd4, 32'd1, 8'd1);
        wait_done("glitch_tmo", 2000, 1'b0);
        check_common("glitch_tmo", 1);
        check_rec(0, 32'd8, 32'd4, 2'b11);
        if (recs.size() > 0) check_eq("glitch_tmo_latency", recs[0].t - t_arm, Timeout + 1);

        // Events landing on the expiry cycle of both waits still win
        glitch_dly = Timeout - 1;
        resp_dly = Timeout - 1;
        resp_ok_cfg = 1'b1;
        start_sweep(32'd9, 32'd9, 32'd1, 32'd6, 32'd6, 32'd1, 8'd1);
        wait_done("expiry", 2000, 1'b0);
        check_common("expiry", 1);
        check_rec(0, 32'd9, 32'd6, 2'b10);

        // Stalled consumer plus boot-banner responses during RESET
        glitch_dly = 0;
        resp_dly = 0;
        resp_ok_cfg = 1'b0;
        banner = 1'b1;
        stall_len = 50;
        stall_peak = 0;
        start_sweep(32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd1, 8'd1);
        wait_done("stall", 2000, 1'b0);
        check_common("stall", 1);
        check_rec(0, 32'd1, 32'd2, 2'b01);
        check_eq("stall_len_held", stall_peak, 50);
        check_eq("stall_stable", 32'(unstable), 0);
        check_eq("stall_fsm_held", 32'(stall_bad), 0);
        banner = 1'b0;
        stall_len = 0;

        // Carry-out of offset and duration must end the range, not wrap
        start_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                    32'd2, 8'd1);
        wait_done("nowrap", 2000, 1'b0);
        check_common("nowrap", 1);
        check_rec(0, 32'hFFFF_FFF0, 32'hFFFF_FFFE, 2'b01);

        // Invalid ranges
        start_sweep(32'd5, 32'd4, 32'd1, 32'd1, 32'd1, 32'd1, 8'd1);
        wait_done("ofs_err", 200, 1'b0);
        check_eq("ofs_err_flag", done_err, 1);
        check_eq("ofs_err_nrec", recs.size(), 0);
        check_eq("ofs_err_nrst", rst_runs.size(), 0);
        start_sweep(32'd1, 32'd1, 32'd1, 32'd9, 32'd8, 32'd1, 8'd1);
        wait_done("dur_err", 200, 1'b0);
        check_eq("dur_err_flag", done_err, 1);
        check_eq("dur_err_nrec", recs.size(), 0);

        // Abort while waiting for the response
        resp_dly = -1;
        start_sweep(32'd9, 32'd9, 32'd1, 32'd1, 32'd1, 32'd1, 8'd1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #2;
            if (o_arm) seen = 1'b1;
        end
        check_eq("abort_wr_arm_seen", 32'(seen), 1);
        repeat (4) @(posedge clk);
        #2;
        d0 = done_cnt;
        i_abort = 1'b1;
        @(posedge clk); #2;
        i_abort = 1'b0;
        check_eq("abort_wr_busy", o_busy, 0);
        check_eq("abort_wr_tgt_reset", o_tgt_reset, 0);
        check_eq("abort_wr_res_valid", res_if.res_valid, 0);
        repeat (Timeout + 20) @(posedge clk);
        #2;
        check_eq("abort_wr_no_done", done_cnt - d0, 0);
        check_eq("abort_wr_nrec", recs.size(), 0);

        // Abort while a record is waiting for the consumer
        resp_dly = 0;
        stall_len = 1000;
        start_sweep(32'd9, 32'd9, 32'd1, 32'd1, 32'd1, 32'd1, 8'd1);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #2;
            if (res_if.res_valid) seen = 1'b1;
        end
        check_eq("abort_rep_valid_seen", 32'(seen), 1);
        repeat (3) @(posedge clk);
        #2;
        d0 = done_cnt;
        i_abort = 1'b1;
        @(posedge clk); #2;
        i_abort = 1'b0;
        check_eq("abort_rep_busy", o_busy, 0);
        check_eq("abort_rep_res_valid", res_if.res_valid, 0);
        repeat (30) @(posedge clk);
        #2;
        check_eq("abort_rep_no_done", done_cnt - d0, 0);
        check_eq("abort_rep_nrec", recs.size(), 0);
        stall_len = 0;

        // Clean sweep after the aborts
        start_sweep(32'd20, 32'd21, 32'd1, 32'd4, 32'd4, 32'd1, 8'd1);
        wait_done("after_abort", 2000, 1'b0);
        check_common("after_abort", 2);
        check_rec(0, 32'd20, 32'd4, 2'b01);
        check_rec(1, 32'd21, 32'd4, 2'b01);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
